interdevice_tx_arbiter: RTL and testbench



---
 rtl/interdevice_tx_arbiter_pkg.sv | 28 ++
 rtl/tx_priority_select_comb.sv | 39 +++
 rtl/interdevice_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_interdevice_tx_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/interdevice_tx_arbiter_pkg.sv
// Shared types for the interdevice TX arbiter: flit layout, winner encoding and grant bit positions.
package interdevice_tx_arbiter_pkg;

  typedef struct packed {
    logic       is_ack;
    logic [3:0] vc;
    logic [7:0] dst_id;
    logic [7:0] seq;
  } flit_header_t;

  typedef struct packed {
    flit_header_t header;
    logic [31:0]  payload;
  } flit_t;

  typedef enum logic [1:0] {
    TX_SRC_NONE,
    TX_SRC_ACK,
    TX_SRC_RESEND,
    TX_SRC_DATA
  } tx_src_t;

  localparam int TX_NUM_SRC = 3;
  localparam int GNT_ACK    = 0;
  localparam int GNT_RESEND = 1;
  localparam int GNT_DATA   = 2;

endpackage

// File: rtl/tx_priority_select_comb.sv
// Pure combinational winner select: ack > resend > data, unless the aging override hands the grant to data.
module tx_priority_select_comb
  import interdevice_tx_arbiter_pkg::*;
(
  input  logic                  i_ack_valid,
  input  logic                  i_resend_valid,
  input  logic                  i_data_valid,
  input  logic                  i_load,
  input  logic                  i_starve_hit,
  output logic [TX_NUM_SRC-1:0] o_grant,
  output tx_src_t               o_winner
);

  always_comb begin
    o_winner = TX_SRC_NONE;
    if (i_load) begin
      if (i_starve_hit && i_data_valid) begin
        o_winner = TX_SRC_DATA;
      end else if (i_ack_valid) begin
        o_winner = TX_SRC_ACK;
      end else if (i_resend_valid) begin
        o_winner = TX_SRC_RESEND;
      end else if (i_data_valid) begin
        o_winner = TX_SRC_DATA;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    case (o_winner)
      TX_SRC_ACK:    o_grant[GNT_ACK]    = 1'b1;
      TX_SRC_RESEND: o_grant[GNT_RESEND] = 1'b1;
      TX_SRC_DATA:   o_grant[GNT_DATA]   = 1'b1;
      default:       o_grant = '0;
    endcase
  end

endmodule

// File: rtl/interdevice_tx_arbiter.sv
// Merges ACK, resend and new data flits into one registered TX link slot with a starvation guard.
// Optional grant/override counters are built when TX_ARB_STATS_EN is defined.
module interdevice_tx_arbiter
  import interdevice_tx_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic  nocclk,
  input  logic  rst_n,
  input  flit_t ack_flit,
  input  logic  ack_flit_valid,
  output logic  ack_flit_ready,
  input  flit_t resend_flit,
  input  logic  resend_flit_valid,
  output logic  resend_flit_ready,
  input  flit_t data_flit,
  input  logic  data_flit_valid,
  output logic  data_flit_ready,
  input  logic  interdevice_tx_ready,
  output logic  interdevice_tx_valid,
  output flit_t interdevice_tx_flit,
  output logic  interdevice_tx_is_resend
`ifdef TX_ARB_STATS_EN
  ,
  output logic [31:0] stat_ack_grants,
  output logic [31:0] stat_resend_grants,
  output logic [31:0] stat_data_grants,
  output logic [31:0] stat_starve_overrides
`endif
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  // Handshake: x_ready is asserted only for the single winning valid source while the
  // output slot can load; a flit moves on any cycle where its valid and ready are both high.
  logic                  r_valid;
  flit_t                 r_flit;
  logic                  r_is_resend;
  logic [CNT_W-1:0]      r_starve_cnt;

  logic                  w_load;
  logic                  w_starve_hit;
  logic [TX_NUM_SRC-1:0] w_grant;
  tx_src_t               w_winner;
  flit_t                 w_win_flit;

  // Gating with rst_n keeps every ready low during reset.
  assign w_load       = rst_n && (!r_valid || interdevice_tx_ready);
  assign w_starve_hit = (r_starve_cnt == LIMIT_C);

  tx_priority_select_comb u_select (
    .i_ack_valid    (ack_flit_valid),
    .i_resend_valid (resend_flit_valid),
    .i_data_valid   (data_flit_valid),
    .i_load         (w_load),
    .i_starve_hit   (w_starve_hit),
    .o_grant        (w_grant),
    .o_winner       (w_winner)
  );

  always_comb begin
    w_win_flit = data_flit;
    case (w_winner)
      TX_SRC_ACK:    w_win_flit = ack_flit;
      TX_SRC_RESEND: w_win_flit = resend_flit;
      default:       w_win_flit = data_flit;
    endcase
  end

  assign ack_flit_ready    = w_grant[GNT_ACK];
  assign resend_flit_ready = w_grant[GNT_RESEND];
  assign data_flit_ready   = w_grant[GNT_DATA];

  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_flit       <= '0;
      r_is_resend  <= 1'b0;
      r_starve_cnt <= '0;
    end else if (w_load) begin
      if (w_winner != TX_SRC_NONE) begin
        r_valid     <= 1'b1;
        r_flit      <= w_win_flit;
        r_is_resend <= (w_winner == TX_SRC_RESEND);
      end else begin
        r_valid <= 1'b0;
      end
      // Only lost arbitration ages data; backpressure cycles never reach here.
      if (!data_flit_valid || w_grant[GNT_DATA]) begin
        r_starve_cnt <= '0;
      end else if (!w_starve_hit) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  assign interdevice_tx_valid     = r_valid;
  assign interdevice_tx_flit      = r_flit;
  assign interdevice_tx_is_resend = r_is_resend;

`ifdef TX_ARB_STATS_EN
  logic [31:0] r_stat_ack;
  logic [31:0] r_stat_resend;
  logic [31:0] r_stat_data;
  logic [31:0] r_stat_override;
  logic        w_override;

  // Counts only grants the override actually changed, i.e. a higher-priority source lost.
  assign w_override = w_grant[GNT_DATA] && w_starve_hit && (ack_flit_valid || resend_flit_valid);

  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      r_stat_ack      <= '0;
      r_stat_resend   <= '0;
      r_stat_data     <= '0;
      r_stat_override <= '0;
    end else begin
      if (w_grant[GNT_ACK])    r_stat_ack      <= r_stat_ack + 32'd1;
      if (w_grant[GNT_RESEND]) r_stat_resend   <= r_stat_resend + 32'd1;
      if (w_grant[GNT_DATA])   r_stat_data     <= r_stat_data + 32'd1;
      if (w_override)          r_stat_override <= r_stat_override + 32'd1;
    end
  end

  assign stat_ack_grants       = r_stat_ack;
  assign stat_resend_grants    = r_stat_resend;
  assign stat_data_grants      = r_stat_data;
  assign stat_starve_overrides = r_stat_override;
`endif

endmodule

// File: tb/tb_interdevice_tx_arbiter.sv
// Randomized and directed bench for interdevice_tx_arbiter against a transaction-level reference model.
module tb_interdevice_tx_arbiter;
  import interdevice_tx_arbiter_pkg::*;

  localparam int LIMIT  = 2;
  localparam int FLIT_W = $bits(flit_t);

  logic  nocclk = 1'b0;
  logic  rst_n = 1'b0;
  flit_t ack_flit = '0;
  logic  ack_flit_valid = 1'b0;
  logic  ack_flit_ready;
  flit_t resend_flit = '0;
  logic  resend_flit_valid = 1'b0;
  logic  resend_flit_ready;
  flit_t data_flit = '0;
  logic  data_flit_valid = 1'b0;
  logic  data_flit_ready;
  logic  interdevice_tx_ready = 1'b0;
  logic  interdevice_tx_valid;
  flit_t interdevice_tx_flit;
  logic  interdevice_tx_is_resend;
`ifdef TX_ARB_STATS_EN
  logic [31:0] stat_ack_grants;
  logic [31:0] stat_resend_grants;
  logic [31:0] stat_data_grants;
  logic [31:0] stat_starve_overrides;
`endif

  // clock / reset
  always #5 nocclk = ~nocclk;

  interdevice_tx_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .nocclk                   (nocclk),
    .rst_n                    (rst_n),
    .ack_flit                 (ack_flit),
    .ack_flit_valid           (ack_flit_valid),
    .ack_flit_ready           (ack_flit_ready),
    .resend_flit              (resend_flit),
    .resend_flit_valid        (resend_flit_valid),
    .resend_flit_ready        (resend_flit_ready),
    .data_flit                (data_flit),
    .data_flit_valid          (data_flit_valid),
    .data_flit_ready          (data_flit_ready),
    .interdevice_tx_ready     (interdevice_tx_ready),
    .interdevice_tx_valid     (interdevice_tx_valid),
    .interdevice_tx_flit      (interdevice_tx_flit),
    .interdevice_tx_is_resend (interdevice_tx_is_resend)
`ifdef TX_ARB_STATS_EN
    ,
    .stat_ack_grants          (stat_ack_grants),
    .stat_resend_grants       (stat_resend_grants),
    .stat_data_grants         (stat_data_grants),
    .stat_starve_overrides    (stat_starve_overrides)
`endif
  );

  // scoreboard and reference model state
  int                n_tests = 0;
  int                n_fail  = 0;
  logic [FLIT_W-1:0] exp_q[$];
  logic              m_valid = 1'b0;
  flit_t             m_flit = '0;
  logic              m_is_resend = 1'b0;
  int                m_starve = 0;
  logic [31:0]       m_stat_ack = '0;
  logic [31:0]       m_stat_resend = '0;
  logic [31:0]       m_stat_data = '0;
  logic [31:0]       m_stat_override = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic flit_t rand_flit(input logic is_ack);
    flit_t f;
    f.header.is_ack = is_ack;
    f.header.vc     = 4'($urandom);
    f.header.dst_id = 8'($urandom);
    f.header.seq    = 8'($urandom);
    f.payload       = $urandom;
    return f;
  endfunction

  // driver: one clock cycle of stimulus plus all checks for that cycle
  task automatic run_cycle(input logic rst, input logic av, input logic rv,
                           input logic dv, input logic txr);
    logic  load;
    int    win;
    flit_t win_flit;
    @(negedge nocclk);
    rst_n                = rst;
    ack_flit_valid       = av;
    resend_flit_valid    = rv;
    data_flit_valid      = dv;
    ack_flit             = rand_flit(1'b1);
    resend_flit          = rand_flit(1'b0);
    data_flit            = rand_flit(1'b0);
    interdevice_tx_ready = txr;
    #1;
    // source code: 0 none, 1 ack, 2 resend, 3 data
    load = rst && (!m_valid || txr);
    win  = 0;
    if (load) begin
      if (m_starve >= LIMIT && dv) win = 3;
      else if (av)                 win = 1;
      else if (rv)                 win = 2;
      else if (dv)                 win = 3;
    end
    check("ack_ready",    64'(ack_flit_ready),    64'(win == 1));
    check("resend_ready", 64'(resend_flit_ready), 64'(win == 2));
    check("data_ready",   64'(data_flit_ready),   64'(win == 3));
    if (rst && m_valid && txr && exp_q.size() != 0)
      check("link_order", 64'(interdevice_tx_flit), 64'(exp_q.pop_front()));
    @(posedge nocclk);
    #1;
    if (!rst) begin
      m_valid = 1'b0; m_flit = '0; m_is_resend = 1'b0; m_starve = 0;
      m_stat_ack = '0; m_stat_resend = '0; m_stat_data = '0; m_stat_override = '0;
      exp_q.delete();
    end else if (load) begin
      if (win == 3 && m_starve >= LIMIT && (av || rv)) m_stat_override++;
      if (win != 0) begin
        win_flit    = (win == 1) ? ack_flit : (win == 2) ? resend_flit : data_flit;
        m_valid     = 1'b1;
        m_flit      = win_flit;
        m_is_resend = (win == 2);
        exp_q.push_back(win_flit);
        if (win == 1) m_stat_ack++;
        if (win == 2) m_stat_resend++;
        if (win == 3) m_stat_data++;
      end else begin
        m_valid = 1'b0;
      end
      if (dv && win != 3) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      else                m_starve = 0;
    end
    check("tx_valid",     64'(interdevice_tx_valid),     64'(m_valid));
    check("tx_flit",      64'(interdevice_tx_flit),      64'(m_flit));
    check("tx_is_resend", 64'(interdevice_tx_is_resend), 64'(m_is_resend));
`ifdef TX_ARB_STATS_EN
    check("stat_ack",      64'(stat_ack_grants),       64'(m_stat_ack));
    check("stat_resend",   64'(stat_resend_grants),    64'(m_stat_resend));
    check("stat_data",     64'(stat_data_grants),      64'(m_stat_data));
    check("stat_override", 64'(stat_starve_overrides), 64'(m_stat_override));
`endif
  endtask

  initial begin
    // reset held with every source offering
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("reset_release_is_ack", 64'(interdevice_tx_flit.header.is_ack), 64'(1));
    // priority: resend beats data, data follows once resend drops
    run_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    // backpressure then release
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    // starvation from a clean reset: ack, ack, data, ack, ack, data
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef TX_ARB_STATS_EN
    check("starve_scn_ack",      64'(stat_ack_grants),       64'(4));
    check("starve_scn_data",     64'(stat_data_grants),      64'(2));
    check("starve_scn_override", 64'(stat_starve_overrides), 64'(2));
`endif
    // back-to-back data then idle
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // randomized traffic with occasional mid-run reset
    for (int i = 0; i < 3000; i++) begin
      run_cycle(logic'($urandom_range(0, 63) != 0),
                logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 2) == 0),
                logic'($urandom_range(0, 3) != 0),
                logic'($urandom_range(0, 3) != 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
